// File: rtl/msm_vector_loader.sv
// Loads point/scalar test vectors into the MSM kernel memories, clears the bucket
// index array first, then launches the kernel and reports completion.
module msm_vector_loader #(
    parameter int unsigned EC_BASE_FIELD_WIDTH   = 377,
    parameter int unsigned EC_SCALAR_FIELD_WIDTH = 253,
    parameter int unsigned ADDR_WIDTH            = 4,
    parameter int unsigned MEM_SIZE              = 16,
    parameter int unsigned B_DEPTH               = 32
) (
    input  logic                             ap_clk,
    input  logic                             ap_rst,
    input  logic                             cfg_start,
    input  logic [ADDR_WIDTH:0]              cfg_num_points,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [EC_BASE_FIELD_WIDTH-1:0]   in_x,
    input  logic [EC_BASE_FIELD_WIDTH-1:0]   in_y,
    input  logic [EC_BASE_FIELD_WIDTH-1:0]   in_z,
    input  logic [EC_SCALAR_FIELD_WIDTH-1:0] in_k,
    output logic [ADDR_WIDTH-1:0]            P_arr_x_V_address0,
    output logic [ADDR_WIDTH-1:0]            P_arr_y_V_address0,
    output logic [ADDR_WIDTH-1:0]            P_arr_z_V_address0,
    output logic [ADDR_WIDTH-1:0]            K_arr_V_address0,
    output logic [EC_BASE_FIELD_WIDTH-1:0]   P_arr_x_V_d0,
    output logic [EC_BASE_FIELD_WIDTH-1:0]   P_arr_y_V_d0,
    output logic [EC_BASE_FIELD_WIDTH-1:0]   P_arr_z_V_d0,
    output logic [EC_SCALAR_FIELD_WIDTH-1:0] K_arr_V_d0,
    output logic                             P_arr_x_V_ce0,
    output logic                             P_arr_x_V_we0,
    output logic                             P_arr_y_V_ce0,
    output logic                             P_arr_y_V_we0,
    output logic                             P_arr_z_V_ce0,
    output logic                             P_arr_z_V_we0,
    output logic                             K_arr_V_ce0,
    output logic                             K_arr_V_we0,
    output logic [4:0]                       B_i_V_address0,
    output logic [31:0]                      B_i_V_d0,
    output logic                             B_i_V_ce0,
    output logic                             B_i_V_we0,
    output logic                             ap_start,
    input  logic                             ap_done,
    output logic                             busy,
    output logic                             done,
    output logic                             err_size
);

    localparam int unsigned CW = ADDR_WIDTH + 1;
    localparam int unsigned BW = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR_B,
        S_LOAD,
        S_START,
        S_DONE
    } state_t;

    state_t                         state_q, state_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [CW-1:0]                  num_q, num_d;
    logic [BW-1:0]                  bcnt_q, bcnt_d;
    logic                           err_d, wr_d, in_ready_d, b_we_d;
    logic                           ap_start_d, busy_d, done_d;
    logic [ADDR_WIDTH-1:0]          waddr_d;
    logic [EC_BASE_FIELD_WIDTH-1:0] x_d, y_d, z_d;
    logic [EC_SCALAR_FIELD_WIDTH-1:0] k_d;

    // Next state and next values of every registered output
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        num_d      = num_q;
        bcnt_d     = bcnt_q;
        err_d      = err_size;
        wr_d       = 1'b0;
        waddr_d    = P_arr_x_V_address0;
        x_d        = P_arr_x_V_d0;
        y_d        = P_arr_y_V_d0;
        z_d        = P_arr_z_V_d0;
        k_d        = K_arr_V_d0;
        unique case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    if (cfg_num_points > CW'(MEM_SIZE)) begin
                        err_d = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        num_d   = cfg_num_points;
                        cnt_d   = '0;
                        bcnt_d  = '0;
                        state_d = S_CLEAR_B;
                    end
                end
            end
            S_CLEAR_B: begin
                if (bcnt_q == BW'(B_DEPTH - 1)) begin
                    state_d = (num_q == '0) ? S_START : S_LOAD;
                end else begin
                    bcnt_d = bcnt_q + BW'(1);
                end
            end
            S_LOAD: begin
                if (in_valid && in_ready) begin
                    wr_d    = 1'b1;
                    waddr_d = cnt_q[ADDR_WIDTH-1:0];
                    x_d     = in_x;
                    y_d     = in_y;
                    z_d     = in_z;
                    k_d     = in_k;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_d == num_q) begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                if (ap_done) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Outputs are aligned with the state being entered
        b_we_d     = (state_d == S_CLEAR_B);
        in_ready_d = (state_d == S_LOAD) && (cnt_d < num_d);
        ap_start_d = (state_d == S_START);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q            <= S_IDLE;
            cnt_q              <= '0;
            num_q              <= '0;
            bcnt_q             <= '0;
            err_size           <= 1'b0;
            in_ready           <= 1'b0;
            P_arr_x_V_we0      <= 1'b0;
            P_arr_y_V_we0      <= 1'b0;
            P_arr_z_V_we0      <= 1'b0;
            K_arr_V_we0        <= 1'b0;
            P_arr_x_V_ce0      <= 1'b0;
            P_arr_y_V_ce0      <= 1'b0;
            P_arr_z_V_ce0      <= 1'b0;
            K_arr_V_ce0        <= 1'b0;
            P_arr_x_V_address0 <= '0;
            P_arr_y_V_address0 <= '0;
            P_arr_z_V_address0 <= '0;
            K_arr_V_address0   <= '0;
            P_arr_x_V_d0       <= '0;
            P_arr_y_V_d0       <= '0;
            P_arr_z_V_d0       <= '0;
            K_arr_V_d0         <= '0;
            B_i_V_address0     <= '0;
            B_i_V_ce0          <= 1'b0;
            B_i_V_we0          <= 1'b0;
            ap_start           <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
        end else begin
            state_q            <= state_d;
            cnt_q              <= cnt_d;
            num_q              <= num_d;
            bcnt_q             <= bcnt_d;
            err_size           <= err_d;
            in_ready           <= in_ready_d;
            P_arr_x_V_we0      <= wr_d;
            P_arr_y_V_we0      <= wr_d;
            P_arr_z_V_we0      <= wr_d;
            K_arr_V_we0        <= wr_d;
            P_arr_x_V_ce0      <= wr_d;
            P_arr_y_V_ce0      <= wr_d;
            P_arr_z_V_ce0      <= wr_d;
            K_arr_V_ce0        <= wr_d;
            P_arr_x_V_address0 <= waddr_d;
            P_arr_y_V_address0 <= waddr_d;
            P_arr_z_V_address0 <= waddr_d;
            K_arr_V_address0   <= waddr_d;
            P_arr_x_V_d0       <= x_d;
            P_arr_y_V_d0       <= y_d;
            P_arr_z_V_d0       <= z_d;
            K_arr_V_d0         <= k_d;
            B_i_V_address0     <= bcnt_d;
            B_i_V_ce0          <= b_we_d;
            B_i_V_we0          <= b_we_d;
            ap_start           <= ap_start_d;
            busy               <= busy_d;
            done               <= done_d;
        end
    end

    assign B_i_V_d0 = 32'd0;

endmodule

// File: tb/tb_msm_vector_loader.sv
// Directed bench for msm_vector_loader: scoreboard of expected memory writes,
// bucket-clear sequence tracking and kernel handshake checks.
module tb_msm_vector_loader;

    localparam int unsigned BW = 377;
    localparam int unsigned SW = 253;
    localparam int unsigned AW = 4;

    logic          ap_clk, ap_rst, cfg_start, in_valid, in_ready, ap_done;
    logic [AW:0]   cfg_num_points;
    logic [BW-1:0] in_x, in_y, in_z;
    logic [SW-1:0] in_k;
    logic [AW-1:0] px_a, py_a, pz_a, k_a;
    logic [BW-1:0] px_d, py_d, pz_d;
    logic [SW-1:0] k_d;
    logic          px_ce, px_we, py_ce, py_we, pz_ce, pz_we, k_ce, k_we;
    logic [4:0]    b_a;
    logic [31:0]   b_d;
    logic          b_ce, b_we, ap_start, busy, done, err_size;

    msm_vector_loader dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .cfg_start(cfg_start), .cfg_num_points(cfg_num_points),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_k(in_k),
        .P_arr_x_V_address0(px_a), .P_arr_y_V_address0(py_a), .P_arr_z_V_address0(pz_a),
        .K_arr_V_address0(k_a), .P_arr_x_V_d0(px_d), .P_arr_y_V_d0(py_d), .P_arr_z_V_d0(pz_d),
        .K_arr_V_d0(k_d), .P_arr_x_V_ce0(px_ce), .P_arr_x_V_we0(px_we), .P_arr_y_V_ce0(py_ce),
        .P_arr_y_V_we0(py_we), .P_arr_z_V_ce0(pz_ce), .P_arr_z_V_we0(pz_we), .K_arr_V_ce0(k_ce),
        .K_arr_V_we0(k_we), .B_i_V_address0(b_a), .B_i_V_d0(b_d), .B_i_V_ce0(b_ce),
        .B_i_V_we0(b_we), .ap_start(ap_start), .ap_done(ap_done), .busy(busy), .done(done),
        .err_size(err_size)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [BW-1:0] x;
        logic [BW-1:0] y;
        logic [BW-1:0] z;
        logic [SW-1:0] k;
    } rec_t;

    rec_t       sb[$];
    int         total = 0;
    int         bad = 0;
    int         pwrites = 0;
    int         bclears = 0;
    int         dones = 0;
    logic [4:0] bexp = '0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [383:0] rnd384();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Observe DUT outputs once per cycle, on the falling edge
    task automatic monitor();
        rec_t r;
        check("strobes_agree", 512'({py_we, pz_we, k_we, px_ce, py_ce, pz_ce, k_ce}), 512'({7{px_we}}));
        check("b_ce_we", 512'(b_ce), 512'(b_we));
        if (px_we) begin
            pwrites++;
            check("write_expected", 512'(sb.size() != 0), 512'(1'b1));
            if (sb.size() != 0) begin
                r = sb.pop_front();
                check("addr_x", 512'(px_a), 512'(r.a));
                check("addrs_yzk", 512'({py_a, pz_a, k_a}), 512'({r.a, r.a, r.a}));
                check("data_x", 512'(px_d), 512'(r.x));
                check("data_y", 512'(py_d), 512'(r.y));
                check("data_z", 512'(pz_d), 512'(r.z));
                check("data_k", 512'(k_d), 512'(r.k));
            end
        end
        if (b_we) begin
            check("b_addr", 512'(b_a), 512'(bexp));
            check("b_d0", 512'(b_d), 512'(0));
            bexp = bexp + 5'd1;
            bclears++;
        end
        if (done) dones++;
    endtask

    task automatic tick();
        @(negedge ap_clk);
        monitor();
    endtask

    task automatic start_cmd(input int n);
        cfg_start      = 1'b1;
        cfg_num_points = 5'(n);
        tick();
        cfg_start      = 1'b0;
    endtask

    // Offer records; pat selects in_valid while in_ready is high, idle_v otherwise
    task automatic feed(input int n, input logic [31:0] pat, input logic idle_v);
        int   got = 0;
        int   cyc = 0;
        int   pidx = 0;
        logic v;
        logic [383:0] t;
        while (got < n && cyc < 400) begin
            if (in_ready) begin
                v = pat[pidx % 32];
                pidx++;
            end else begin
                v = idle_v;
            end
            in_valid = v;
            t = rnd384(); in_x = t[BW-1:0];
            t = rnd384(); in_y = t[BW-1:0];
            t = rnd384(); in_z = t[BW-1:0];
            t = rnd384(); in_k = t[SW-1:0];
            if (v && in_ready) begin
                sb.push_back('{a: AW'(got), x: in_x, y: in_y, z: in_z, k: in_k});
                got++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check("feed_count", 512'(got), 512'(n));
    endtask

    task automatic wait_start(output int cnt);
        cnt = 0;
        while (!ap_start && cnt < 200) begin
            tick();
            cnt++;
        end
        check("ap_start_seen", 512'(ap_start), 512'(1'b1));
    endtask

    task automatic no_more_accept(input int wexp);
        in_valid = 1'b1;
        repeat (3) begin
            tick();
            check("in_ready_low", 512'(in_ready), 512'(1'b0));
        end
        in_valid = 1'b0;
        check("write_total", 512'(pwrites), 512'(wexp));
        check("sb_drained", 512'(sb.size()), 512'(0));
    endtask

    task automatic kernel(input int m);
        repeat (m) begin
            tick();
            check("ap_start_hold", 512'(ap_start), 512'(1'b1));
        end
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        check("ap_start_drop", 512'(ap_start), 512'(1'b0));
        check("done_pulse", 512'(done), 512'(1'b1));
        tick();
        check("done_one_cycle", 512'(done), 512'(1'b0));
        check("busy_after", 512'(busy), 512'(1'b0));
    endtask

    initial begin
        int w0, b0, d0, cnt;
        ap_rst = 1'b1; cfg_start = 1'b0; cfg_num_points = '0; in_valid = 1'b0; ap_done = 1'b0;
        in_x = '0; in_y = '0; in_z = '0; in_k = '0;
        tick();
        tick();
        check("rst_strobes", 512'({px_we, b_we, in_ready, ap_start, busy, done, err_size}), 512'(0));
        check("rst_addr_data", 512'({px_a, b_a, px_d[100:0]}), 512'(0));
        ap_rst = 1'b0;

        // N=3, valid held high throughout
        w0 = pwrites; b0 = bclears;
        start_cmd(3);
        feed(3, 32'hFFFF_FFFF, 1'b1);
        wait_start(cnt);
        check("t1_clears", 512'(bclears - b0), 512'(32));
        no_more_accept(w0 + 3);
        kernel(10);

        // N=4 with gapped valid
        w0 = pwrites;
        start_cmd(4);
        feed(4, 32'b101101, 1'b0);
        no_more_accept(w0 + 4);
        kernel(2);

        // N=0: clear only, then straight to start
        w0 = pwrites; b0 = bclears;
        start_cmd(0);
        wait_start(cnt);
        check("t3_start_latency", 512'(cnt), 512'(32));
        check("t3_clears", 512'(bclears - b0), 512'(32));
        check("t3_no_writes", 512'(pwrites - w0), 512'(0));
        kernel(1);

        // N=17 rejected, then N=2 accepted
        w0 = pwrites; b0 = bclears;
        start_cmd(17);
        check("t4_err_set", 512'(err_size), 512'(1'b1));
        repeat (3) tick();
        check("t4_idle", 512'({busy, err_size}), 512'(2'b01));
        check("t4_no_activity", 512'((pwrites - w0) + (bclears - b0)), 512'(0));
        start_cmd(2);
        check("t4_err_clear", 512'({busy, err_size}), 512'(2'b10));
        feed(2, 32'hFFFF_FFFF, 1'b0);
        no_more_accept(w0 + 2);
        kernel(3);

        // N=16 full memory, irregular valid
        w0 = pwrites;
        start_cmd(16);
        feed(16, 32'hB6DB_7EED, 1'b0);
        check("t5_last_addr", 512'(px_a), 512'(15));
        no_more_accept(w0 + 16);
        kernel(4);

        // Reset during LOAD after two writes
        w0 = pwrites; d0 = dones;
        start_cmd(5);
        feed(2, 32'hFFFF_FFFF, 1'b0);
        ap_rst = 1'b1;
        tick();
        check("t6_rst_strobes", 512'({px_we, py_we, pz_we, k_we, b_we}), 512'(0));
        check("t6_rst_ctrl", 512'({in_ready, ap_start, busy, done}), 512'(0));
        ap_rst = 1'b0;
        tick();
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        repeat (3) tick();
        check("t6_no_done", 512'(dones - d0), 512'(0));
        check("t6_writes", 512'(pwrites - w0), 512'(2));
        check("t6_idle", 512'({busy, ap_start}), 512'(0));
        sb.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/msm_vector_loader.md
Name: msm_vector_loader

Overview:
Upstream feeder for the MSM kernel's test-vector memory. Clears the 32-entry bucket-index array and streams N point/scalar records from a valid/ready source into the P_arr_x/y/z and K_arr write ports (port 0). It then launches the HLS kernel with ap_start, holds until ap_done, and reports completion. Used in the MSM tester bench between the vector source and the test-case memory.

Parameters:
EC_BASE_FIELD_WIDTH, 377, width of x/y/z coordinates
EC_SCALAR_FIELD_WIDTH, 253, width of scalar k
ADDR_WIDTH, 4, point/scalar memory address width
MEM_SIZE, 16, number of point/scalar entries (<= 2**ADDR_WIDTH)
B_DEPTH, 32, bucket-index array entries (5-bit address)

Ports:
ap_clk  in  1  clock, all logic on rising edge
ap_rst  in  1  synchronous active-high reset
cfg_start  in  1  single-cycle request to begin a load; sampled only in IDLE
cfg_num_points  in  ADDR_WIDTH+1  record count N, sampled with cfg_start
in_valid  in  1  source record valid
in_ready  out  1  loader accepts record
in_x / in_y / in_z  in  EC_BASE_FIELD_WIDTH each  point coordinates
in_k  in  EC_SCALAR_FIELD_WIDTH  scalar
P_arr_x_V_address0 / P_arr_y_V_address0 / P_arr_z_V_address0 / K_arr_V_address0  out  ADDR_WIDTH each  write address
P_arr_x_V_d0 / P_arr_y_V_d0 / P_arr_z_V_d0  out  EC_BASE_FIELD_WIDTH each  write data
K_arr_V_d0  out  EC_SCALAR_FIELD_WIDTH  write data
P_arr_x_V_ce0/we0, P_arr_y_V_ce0/we0, P_arr_z_V_ce0/we0, K_arr_V_ce0/we0  out  1 each  enable/write strobe (ce0 = we0)
B_i_V_address0  out  5  bucket clear address
B_i_V_d0  out  32  always 0
B_i_V_ce0 / B_i_V_we0  out  1  bucket clear strobe
ap_start  out  1  kernel start
ap_done  in  1  kernel done pulse
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse when kernel finished
err_size  out  1  sticky: cfg_num_points > MEM_SIZE; cleared by next accepted cfg_start or reset

Behaviour:
- Reset: state IDLE; all outputs 0 (in_ready, every we/ce, addresses, data, ap_start, busy, done, err_size); record counter 0. Reset mid-operation aborts immediately, no further writes.
- All outputs registered.
- IDLE: cfg_start=1 and N<=MEM_SIZE -> latch N, clear err_size, go CLEAR_B. N>MEM_SIZE -> set err_size, stay IDLE, no writes.
- CLEAR_B: 32 consecutive cycles of B_i_V_we0=1, address 0..31, d0=0; after address 31 go LOAD, or START if N=0.
- LOAD: in_ready=1 while counter<N. Handshake (in_valid&in_ready) in cycle t -> cycle t+1: all four we0/ce0=1, address=counter value at t, data=record. Counter increments per handshake; no write in cycles without handshake. in_ready drops the cycle after the Nth handshake; after the Nth write go START. Back-to-back handshakes give one write per cycle.
- START: ap_start=1 held until ap_done sampled high; ap_start deasserts the cycle after; go DONE. ap_done outside START ignored.
- DONE: done=1 for exactly one cycle; return IDLE.
- cfg_start outside IDLE ignored. in_valid outside LOAD ignored (in_ready=0). Address width: counter ADDR_WIDTH+1 bits; address output uses low ADDR_WIDTH bits (N=MEM_SIZE=16 writes 0..15).

Test Plan:
- Reset, cfg_start N=3, valid held high -> B_i writes addr 0..31 data 0 over 32 cycles; then 3 consecutive writes addr 0,1,2 with records; ap_start rises; ap_done after 10 cycles -> done pulse 1 cycle later, busy low.
- N=4 with in_valid toggling 1,0,1,1,0,1 -> exactly 4 writes, addresses 0..3 in order, no write on idle cycles, no 5th acceptance.
- N=0 -> 32 B_i clears, no point writes, ap_start straight after clear.
- N=17 -> err_size=1, busy stays 0, no we strobes; following cfg_start N=2 clears err_size and loads normally.
- N=16 full load -> addresses 0..15, last record at address 15, no wrap to 0.
- ap_rst asserted during LOAD after 2 writes -> next cycle all strobes 0, in_ready 0, ap_start 0, busy 0; ap_done pulse afterwards yields no done.
